// File: rtl/opcode_dispatch_arbiter_if.sv
// Request/response bundle between opcode sources, the dispatch arbiter
// and the downstream classifier consumer. The arbiter takes the slave
// modport; the master modport is the mirror view used by the sources and
// the consumer.
interface opcode_dispatch_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned OPW  = 8,
  parameter int unsigned CW   = 8
);
  localparam int unsigned SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]     req_valid;
  logic [NREQ*OPW-1:0] req_opcode;
  logic [NREQ-1:0]     req_ready;

  logic                out_valid;
  logic                out_ready;
  logic [OPW-1:0]      out_opcode;
  logic                out_type;
  logic [SW-1:0]       out_src;

  logic                err_pulse;
  logic                err_sticky;
  logic [CW-1:0]       err_count;
  logic                err_clear;

  modport master (
    output req_valid, req_opcode, out_ready, err_clear,
    input  req_ready, out_valid, out_opcode, out_type, out_src,
           err_pulse, err_sticky, err_count
  );

  modport slave (
    input  req_valid, req_opcode, out_ready, err_clear,
    output req_ready, out_valid, out_opcode, out_type, out_src,
           err_pulse, err_sticky, err_count
  );
endinterface

// File: rtl/opcode_dispatch_arbiter.sv
// Round-robin dispatch arbiter for a shared opcode classifier.
// Grants one requester per cycle into a single registered output slot,
// classifies legal opcodes (< 64) by bit 5, and drops/counts illegal ones.
// Optional build macro: OPCODE_DISPATCH_DEFERRED_ASSERT_EN adds deferred
// immediate assertions on the handshake and output invariants.
module opcode_dispatch_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned OPW  = 8,
  parameter int unsigned CW   = 8
) (
  input  logic clk,
  input  logic rst_n,
  opcode_dispatch_arbiter_if.slave bus
);
  localparam int unsigned SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [SW-1:0]   rr_ptr;
  logic            free_c;
  logic            found_c;
  logic [SW-1:0]   gnt_idx_c;
  logic [OPW-1:0]  gnt_opcode_c;
  logic            gnt_illegal_c;
  logic            accept_c;
  int unsigned     scan_idx;

  // Find the first valid requester at or after the RR pointer, with wrap.
  always_comb begin
    found_c   = 1'b0;
    gnt_idx_c = '0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = (int'(rr_ptr) + k) % NREQ;
      if (!found_c && bus.req_valid[scan_idx]) begin
        found_c   = 1'b1;
        gnt_idx_c = SW'(scan_idx);
      end
    end
  end

  // Slot availability, grant vector and classification of the granted opcode.
  always_comb begin
    free_c        = !bus.out_valid || bus.out_ready;
    accept_c      = rst_n && free_c && found_c;
    bus.req_ready = '0;
    if (accept_c) begin
      bus.req_ready[gnt_idx_c] = 1'b1;
    end
    gnt_opcode_c  = bus.req_opcode[int'(gnt_idx_c)*OPW +: OPW];
    gnt_illegal_c = |gnt_opcode_c[OPW-1:6];
  end

  // Output slot, RR pointer and error bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr         <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_opcode <= '0;
      bus.out_type   <= 1'b0;
      bus.out_src    <= '0;
      bus.err_pulse  <= 1'b0;
      bus.err_sticky <= 1'b0;
      bus.err_count  <= '0;
    end else begin
      bus.err_pulse <= accept_c && gnt_illegal_c;

      if (accept_c) begin
        rr_ptr <= (gnt_idx_c == SW'(NREQ - 1)) ? '0 : gnt_idx_c + SW'(1);
      end

      if (accept_c && !gnt_illegal_c) begin
        bus.out_valid  <= 1'b1;
        bus.out_opcode <= gnt_opcode_c;
        bus.out_type   <= gnt_opcode_c[5];
        bus.out_src    <= gnt_idx_c;
      end else if (bus.out_ready) begin
        // Illegal accepts also land here: the slot was free, so it empties.
        bus.out_valid <= 1'b0;
      end

      // A clear coinciding with an illegal accept clears first, then records.
      if (accept_c && gnt_illegal_c) begin
        bus.err_sticky <= 1'b1;
        if (bus.err_clear) begin
          bus.err_count <= CW'(1);
        end else if (bus.err_count != '1) begin
          bus.err_count <= bus.err_count + CW'(1);
        end
      end else if (bus.err_clear) begin
        bus.err_sticky <= 1'b0;
        bus.err_count  <= '0;
      end
    end
  end

`ifdef OPCODE_DISPATCH_DEFERRED_ASSERT_EN
  // Deferred checks so that intra-timestep glitches never report.
  always_comb begin
    a_ready_onehot: assert #0 ($onehot0(bus.req_ready))
      else $error("req_ready not one-hot-or-zero: %b", bus.req_ready);
    a_ready_valid: assert #0 ((bus.req_ready & ~bus.req_valid) == '0)
      else $error("req_ready without req_valid: ready %b valid %b", bus.req_ready, bus.req_valid);
    a_out_legal: assert #0 (!bus.out_valid || (bus.out_opcode[OPW-1:6] == '0))
      else $error("illegal opcode on output: %0d", bus.out_opcode);
    a_out_type: assert #0 (!bus.out_valid || (bus.out_type == bus.out_opcode[5]))
      else $error("out_type mismatch for opcode %0d", bus.out_opcode);
    a_opcode_err: assert #0 (!(accept_c && gnt_illegal_c))
      else $error("Opcode error from src %0d, opcode %0d", gnt_idx_c, gnt_opcode_c);
  end
`endif

endmodule

// File: tb/tb_opcode_dispatch_arbiter.sv
// Bench for opcode_dispatch_arbiter: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_opcode_dispatch_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned OPW  = 8;
  localparam int unsigned CW   = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  opcode_dispatch_arbiter_if #(.NREQ(NREQ), .OPW(OPW), .CW(CW)) bus ();

  opcode_dispatch_arbiter #(.NREQ(NREQ), .OPW(OPW), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int m_ptr, m_ov, m_op, m_type, m_src, m_pulse, m_sticky, m_cnt;

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic [31:0] ops;
    logic        ordy;
    logic        clr;
    logic [3:0]  e_ready;
    logic        e_ov;
    logic [7:0]  e_op;
    logic        e_type;
    logic [1:0]  e_src;
    logic        e_pulse;
    logic        e_sticky;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(logic r, logic [3:0] v, logic [31:0] o, logic ordy, logic clr,
                              logic [3:0] er, logic eov, logic [7:0] eop, logic ety,
                              logic [1:0] es, logic ep, logic est, logic [7:0] ec);
    vec_t t;
    t.rst_n = r; t.valid = v; t.ops = o; t.ordy = ordy; t.clr = clr;
    t.e_ready = er; t.e_ov = eov; t.e_op = eop; t.e_type = ety; t.e_src = es;
    t.e_pulse = ep; t.e_sticky = est; t.e_cnt = ec;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int opc_of(int i);
    logic [31:0] w;
    w = 32'(bus.req_opcode);
    return int'(w[i*8 +: 8]);
  endfunction

  // Model's choice of grant for the current inputs; -1 when none.
  function automatic int model_pick();
    int i;
    if (!rst_n) return -1;
    if (m_ov != 0 && !bus.out_ready) return -1;
    for (int k = 0; k < NREQ; k++) begin
      i = (m_ptr + k) % NREQ;
      if (bus.req_valid[i]) return i;
    end
    return -1;
  endfunction

  // Apply current inputs for one clock; checks grant before the edge and
  // registered outputs after it against the model.
  task automatic step();
    int g, op, exp_ready;
    g = model_pick();
    exp_ready = (g >= 0) ? (1 << g) : 0;
    #1;
    chk("req_ready", int'(bus.req_ready), exp_ready);
    @(posedge clk);
    if (!rst_n) begin
      m_ptr = 0; m_ov = 0; m_op = 0; m_type = 0; m_src = 0;
      m_pulse = 0; m_sticky = 0; m_cnt = 0;
    end else begin
      m_pulse = 0;
      op = (g >= 0) ? opc_of(g) : 0;
      if (g >= 0) begin
        m_ptr = (g + 1) % NREQ;
        if (op < 64) begin
          m_ov = 1; m_op = op; m_type = (op >= 32) ? 1 : 0; m_src = g;
        end else begin
          m_ov = 0; m_pulse = 1; m_sticky = 1;
          m_cnt = bus.err_clear ? 1 : ((m_cnt + 1 > 255) ? 255 : m_cnt + 1);
        end
      end else if (bus.out_ready) begin
        m_ov = 0;
      end
      if (!(g >= 0 && op >= 64) && bus.err_clear) begin
        m_sticky = 0; m_cnt = 0;
      end
    end
    @(negedge clk);
    chk("out_valid", int'(bus.out_valid), m_ov);
    chk("err_pulse", int'(bus.err_pulse), m_pulse);
    chk("err_sticky", int'(bus.err_sticky), m_sticky);
    chk("err_count", int'(bus.err_count), m_cnt);
    if (m_ov != 0 || !rst_n) begin
      chk("out_opcode", int'(bus.out_opcode), m_op);
      chk("out_type", int'(bus.out_type), m_type);
      chk("out_src", int'(bus.out_src), m_src);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic [31:0] o,
                       input logic ordy, input logic clr);
    rst_n = r;
    bus.req_valid = v;
    bus.req_opcode = o;
    bus.out_ready = ordy;
    bus.err_clear = clr;
  endtask

  initial begin
    logic [31:0] rops;
    logic [3:0]  er;

    // Directed vectors: reset, single requester, round-robin, backpressure,
    // release back-to-back, drain, illegal opcodes and err_clear alone.
    tbl[0]  = mk(0, 4'b1111, {8'd4,8'd3,8'd2,8'd1}, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = tbl[0];
    tbl[2]  = tbl[0];
    tbl[3]  = mk(1, 4'b0100, {8'd0,8'd17,8'd0,8'd0}, 1, 0, 4'b0100, 1, 17, 0, 2, 0, 0, 0);
    tbl[4]  = mk(1, 4'b1111, {8'd43,8'd42,8'd41,8'd40}, 1, 0, 4'b1000, 1, 43, 1, 3, 0, 0, 0);
    tbl[5]  = mk(1, 4'b1111, {8'd43,8'd42,8'd41,8'd40}, 1, 0, 4'b0001, 1, 40, 1, 0, 0, 0, 0);
    tbl[6]  = mk(1, 4'b1111, {8'd43,8'd42,8'd41,8'd40}, 1, 0, 4'b0010, 1, 41, 1, 1, 0, 0, 0);
    tbl[7]  = mk(1, 4'b1111, {8'd43,8'd42,8'd41,8'd40}, 1, 0, 4'b0100, 1, 42, 1, 2, 0, 0, 0);
    tbl[8]  = mk(1, 4'b1111, {8'd43,8'd42,8'd41,8'd40}, 1, 0, 4'b1000, 1, 43, 1, 3, 0, 0, 0);
    tbl[9]  = mk(1, 4'b1111, {8'd43,8'd42,8'd41,8'd40}, 1, 0, 4'b0001, 1, 40, 1, 0, 0, 0, 0);
    for (int i = 10; i < 15; i++)
      tbl[i] = mk(1, 4'b1111, {8'd43,8'd42,8'd41,8'd40}, 0, 0, 4'b0000, 1, 40, 1, 0, 0, 0, 0);
    tbl[15] = mk(1, 4'b1111, {8'd43,8'd42,8'd41,8'd40}, 1, 0, 4'b0010, 1, 41, 1, 1, 0, 0, 0);
    tbl[16] = mk(1, 4'b0000, {8'd43,8'd42,8'd41,8'd40}, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    tbl[17] = mk(1, 4'b0010, {8'd0,8'd0,8'd64,8'd0}, 1, 0, 4'b0010, 0, 0, 0, 0, 1, 1, 1);
    tbl[18] = mk(1, 4'b0010, {8'd0,8'd0,8'd255,8'd0}, 1, 0, 4'b0010, 0, 0, 0, 0, 1, 1, 2);
    tbl[19] = mk(1, 4'b0000, {8'd0,8'd0,8'd0,8'd0}, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 2);
    tbl[20] = mk(1, 4'b0000, {8'd0,8'd0,8'd0,8'd0}, 1, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0);

    m_ptr = 0; m_ov = 0; m_op = 0; m_type = 0; m_src = 0;
    m_pulse = 0; m_sticky = 0; m_cnt = 0;
    drive(0, 4'b0000, '0, 0, 0);
    @(negedge clk);

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].rst_n, tbl[i].valid, tbl[i].ops, tbl[i].ordy, tbl[i].clr);
      #1;
      chk($sformatf("vec%0d req_ready", i), int'(bus.req_ready), int'(tbl[i].e_ready));
      #0;
      // step() re-applies the same inputs; it starts 1 ns late, which is harmless.
      step();
      chk($sformatf("vec%0d out_valid", i), int'(bus.out_valid), int'(tbl[i].e_ov));
      chk($sformatf("vec%0d err_pulse", i), int'(bus.err_pulse), int'(tbl[i].e_pulse));
      chk($sformatf("vec%0d err_sticky", i), int'(bus.err_sticky), int'(tbl[i].e_sticky));
      chk($sformatf("vec%0d err_count", i), int'(bus.err_count), int'(tbl[i].e_cnt));
      if (tbl[i].e_ov) begin
        chk($sformatf("vec%0d out_opcode", i), int'(bus.out_opcode), int'(tbl[i].e_op));
        chk($sformatf("vec%0d out_type", i), int'(bus.out_type), int'(tbl[i].e_type));
        chk($sformatf("vec%0d out_src", i), int'(bus.out_src), int'(tbl[i].e_src));
      end
    end

    // Clear collision: build err_count to 7, then clear with an illegal accept.
    for (int i = 0; i < 7; i++) begin
      drive(1, 4'b0001, {8'd0,8'd0,8'd0,8'd100}, 1, 0);
      step();
    end
    chk("pre_collision count", int'(bus.err_count), 7);
    drive(1, 4'b0001, {8'd0,8'd0,8'd0,8'd128}, 1, 1);
    step();
    chk("collision count", int'(bus.err_count), 1);
    chk("collision sticky", int'(bus.err_sticky), 1);
    chk("collision pulse", int'(bus.err_pulse), 1);
    drive(1, 4'b0000, '0, 1, 0);
    step();
    chk("pulse single cycle", int'(bus.err_pulse), 0);

    // Saturation: 260 illegal accepts must leave the counter at its maximum.
    for (int i = 0; i < 260; i++) begin
      drive(1, 4'b1000, {8'd200,8'd0,8'd0,8'd0}, 1, 0);
      step();
    end
    chk("saturated count", int'(bus.err_count), 255);
    chk("no output from illegal", int'(bus.out_valid), 0);

    // Reset mid-transfer discards a held output entry.
    drive(1, 4'b0001, {8'd0,8'd0,8'd0,8'd33}, 0, 0);
    step();
    chk("held before reset", int'(bus.out_valid), 1);
    drive(0, 4'b1111, {8'd1,8'd2,8'd3,8'd4}, 0, 0);
    step();
    chk("reset drops entry", int'(bus.out_valid), 0);
    chk("reset clears count", int'(bus.err_count), 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++)
        rops[i*8 +: 8] = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(0, 63))
                                                     : 8'($urandom_range(64, 255));
      er = 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 199) != 0), er, rops,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
